quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
Front-end stage that drives the up/down counter. It converts raw two-phase quadrature inputs (A/B, asynchronous to clk) into a one-cycle count-enable pulse plus a direction level. The counter consumes these directly: step gates the counter, and up_down selects its direction. The block also synchronizes and deglitches the inputs, and flags illegal double transitions.

Parameters:
FILTER_LEN, 3, consecutive identical synchronized samples required before a channel's filtered value changes (legal values >= 1)
ERR_W, 2, width of saturating illegal-transition counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
a_in  input  1  raw quadrature channel A, asynchronous
b_in  input  1  raw quadrature channel B, asynchronous
step  output  1  one-cycle pulse per legal quadrature transition
up_down  output  1  direction of the most recent legal step (1 = up, 0 = down)
error  output  1  one-cycle pulse on illegal transition (both filtered channels change in the same cycle)
err_count  output  ERR_W  saturating count of error pulses
ab_state  output  2  current filtered state {A,B}

Behaviour:
- Reset (reset==0 at a clk edge):
  - step=0, error=0, up_down=1, err_count=0, ab_state=2'b00.
  - Synchronizer flops, filter counters and settle counter all clear.
  - The FSM enters INIT.
  - Reset low mid-operation takes effect on that same edge and overrides every other event.
- Synchronizer: two flops per channel, giving 2 cycles of latency.
- Glitch filter (per channel):
  - The counter increments while the synchronized value differs from the filtered value.
  - The counter clears whenever the synchronized value equals the filtered value.
  - When the counter reaches FILTER_LEN, the filtered value takes the synchronized value and the counter clears.
  - A pulse shorter than FILTER_LEN cycles never reaches the filtered value.
- FSM INIT:
  - A settle counter runs for FILTER_LEN+2 cycles after reset deasserts.
  - It then loads the filtered A/B directly from the synchronized values and sets ab_state.
  - No step or error is produced by this load.
  - The FSM then moves to RUN.
  - step and error are held 0 throughout INIT.
- FSM RUN: compare the new filtered {A,B} against the previous value every cycle.
  - Up sequence: 00->10->11->01->00 (A leads B). The block pulses step and registers up_down=1 in the same cycle as the step pulse.
  - Down sequence: 00->01->11->10->00. The block pulses step and registers up_down=0 in the same cycle as the step pulse.
  - No change: step=0. up_down holds its last value.
  - Both bits change (00<->11, 10<->01): error=1 for one cycle and step=0. up_down is unchanged. The new state is adopted. err_count increments, saturating at 2^ERR_W-1 (cleared only by reset).
- Outputs are registered.
- Latency: from the first clk edge that samples a new a_in/b_in level, step is high after exactly FILTER_LEN+3 edges.
- A direction reversal mid-sequence is legal and produces a step with the new direction.
- Minimum legal spacing between transitions is FILTER_LEN+1 cycles. Closer spacing may be lost, but is never reported as a false step in the wrong direction.

Test Plan:
1. a_in=1, b_in=1 held through reset and release (FILTER_LEN=3) -> ab_state=11 after INIT; step and error never asserted; up_down=1.
2. Up sequence 00->10->11->01->00, one transition every 10 cycles -> 4 step pulses, each 6 cycles after the input edge; up_down=1; downstream counter (WIDTH=2) advances 0,1,2,3,0.
3. Down sequence from 00 (00->01->11->10->00) -> 4 step pulses; up_down=0 on the first pulse and after; ab_state ends 00.
4. Glitches on a_in lasting 1 and then 2 cycles (< FILTER_LEN) from state 00 -> no step, ab_state stays 00; a 3-cycle pulse produces a step (up) and then a step (down).
5. a_in and b_in toggled together 00->11 -> error pulse, no step, err_count=1; repeat 5 double-toggles -> err_count saturates at 3, up_down unchanged.
6. reset driven low during a step-producing cycle mid-sequence -> at that edge step=0, err_count=0, up_down=1, ab_state=00; INIT rerun after release.

Source files
------------

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder: sync, deglitch, step/direction and illegal-transition flagging
module quad_decoder #(
    parameter int FILTER_LEN = 3,
    parameter int ERR_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    output logic             step,
    output logic             up_down,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       ab_state
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int SW = $clog2(FILTER_LEN + 2);
    localparam logic [CW-1:0]    FILT_LAST   = CW'(FILTER_LEN - 1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(FILTER_LEN + 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     sync1;
    logic [1:0]     sync2;
    logic [1:0]     filt;
    logic [CW-1:0]  fcnt [2];
    logic [SW-1:0]  settle;
    logic           settle_done;
    logic [1:0]     diff;
    logic           step_nxt;
    logic           error_nxt;
    logic           dir_nxt;
    logic [1:0]     ab_nxt;
    logic [ERR_W-1:0] errc_nxt;

    // bit 1 carries channel A, bit 0 channel B throughout
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {a_in, b_in};
            sync2 <= sync1;
        end
    end

    assign settle_done = (state == S_INIT) && (settle == SETTLE_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            settle <= '0;
        end else if ((state == S_INIT) && !settle_done) begin
            settle <= settle + SW'(1);
        end
    end

    // Filters are frozen during INIT and preloaded directly from the synchronizer when it ends
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                fcnt[i] <= '0;
                filt[i] <= 1'b0;
            end else if (state == S_INIT) begin
                fcnt[i] <= '0;
                if (settle_done) begin
                    filt[i] <= sync2[i];
                end
            end else if (sync2[i] == filt[i]) begin
                fcnt[i] <= '0;
            end else if (fcnt[i] == FILT_LAST) begin
                filt[i] <= sync2[i];
                fcnt[i] <= '0;
            end else begin
                fcnt[i] <= fcnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (settle_done) begin
            state_nxt = S_RUN;
        end
    end

    // ab_state doubles as the previous filtered state for transition classification
    always_comb begin
        step_nxt  = 1'b0;
        error_nxt = 1'b0;
        dir_nxt   = up_down;
        ab_nxt    = ab_state;
        errc_nxt  = err_count;
        diff      = filt ^ ab_state;
        case (state)
            S_INIT: begin
                if (settle_done) begin
                    ab_nxt = sync2;
                end
            end
            S_RUN: begin
                ab_nxt = filt;
                if (diff == 2'b11) begin
                    error_nxt = 1'b1;
                    if (err_count != ERR_MAX) begin
                        errc_nxt = err_count + ERR_W'(1);
                    end
                end else if (diff != 2'b00) begin
                    step_nxt = 1'b1;
                    // A leading B means the old A level matches the new B level
                    dir_nxt  = ~(ab_state[1] ^ filt[0]);
                end
            end
            default: begin
                ab_nxt = ab_state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            step      <= 1'b0;
            error     <= 1'b0;
            up_down   <= 1'b1;
            err_count <= '0;
            ab_state  <= 2'b00;
        end else begin
            step      <= step_nxt;
            error     <= error_nxt;
            up_down   <= dir_nxt;
            err_count <= errc_nxt;
            ab_state  <= ab_nxt;
        end
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder with a sequence-position reference model
module tb_quad_decoder;
    localparam int FL   = 3;
    localparam int EW   = 2;
    localparam int LAT  = FL + 3;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          a_in = 1'b0;
    logic          b_in = 1'b0;
    logic          step;
    logic          up_down;
    logic          error;
    logic [EW-1:0] err_count;
    logic [1:0]    ab_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic          kind;
        logic          dir;
        logic [1:0]    ab;
        logic [EW-1:0] errc;
        logic [31:0]   cycle;
    } ev_t;

    ev_t        exp_q[$];
    logic [1:0] m_ab = 2'b00;
    logic       m_dir = 1'b1;
    int         m_errc = 0;
    logic [1:0] up_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] nab;
    ev_t        mon_act;
    ev_t        mon_exp;

    quad_decoder #(.FILTER_LEN(FL), .ERR_W(EW)) dut (
        .clk(clk),
        .reset(reset),
        .a_in(a_in),
        .b_in(b_in),
        .step(step),
        .up_down(up_down),
        .error(error),
        .err_count(err_count),
        .ab_state(ab_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 20000) begin
            $display("FAIL watchdog cycles=%0d required<20000", cyc);
            $fatal(1);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pos(input logic [1:0] v);
        for (int i = 0; i < 4; i++) begin
            if (up_seq[i] == v) return i;
        end
        return 0;
    endfunction

    task automatic push_ev(input logic kind, input logic [1:0] ab, input int at);
        ev_t e;
        e.kind  = kind;
        e.dir   = m_dir;
        e.ab    = ab;
        e.errc  = EW'(m_errc);
        e.cycle = 32'(at);
        exp_q.push_back(e);
    endtask

    // distance along the up sequence: +1 up, -1 down, 2 both channels changed
    task automatic apply(input logic [1:0] v, input int hold);
        int d;
        a_in = v[1];
        b_in = v[0];
        d = (pos(v) - pos(m_ab) + 4) % 4;
        if (d == 1 || d == 3) begin
            m_dir = (d == 1);
            push_ev(1'b0, v, cyc + LAT);
        end else if (d == 2) begin
            if (m_errc < EMAX) m_errc++;
            push_ev(1'b1, v, cyc + LAT);
        end
        m_ab = v;
        repeat (hold) @(negedge clk);
    endtask

    task automatic pulse_a(input int w);
        a_in = 1'b1;
        if (w >= FL) begin
            m_dir = 1'b1;
            push_ev(1'b0, 2'b10, cyc + LAT);
        end
        repeat (w) @(negedge clk);
        a_in = 1'b0;
        if (w >= FL) begin
            m_dir = 1'b0;
            push_ev(1'b0, 2'b00, cyc + LAT);
        end
        repeat (12) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset && (step || error)) begin
            mon_act.kind  = error;
            mon_act.dir   = up_down;
            mon_act.ab    = ab_state;
            mon_act.errc  = err_count;
            mon_act.cycle = 32'(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual=%0h required=none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event", 64'(mon_act), 64'(mon_exp));
            end
        end
    end

    initial begin
        a_in  = 1'b1;
        b_in  = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_step", 64'(step), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_up_down", 64'(up_down), 64'(1));
        check("rst_err_count", 64'(err_count), 64'(0));
        check("rst_ab_state", 64'(ab_state), 64'(0));
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("init_ab_state", 64'(ab_state), 64'(2'b11));
        check("init_up_down", 64'(up_down), 64'(1));
        m_ab = 2'b11;
        apply(2'b01, 10);
        apply(2'b00, 10);

        foreach (up_seq[i]) apply(up_seq[(i + 1) % 4], 10);
        apply(2'b01, 10);
        apply(2'b11, 10);
        apply(2'b10, 10);
        apply(2'b00, 10);
        check("down_up_down", 64'(up_down), 64'(0));

        pulse_a(1);
        pulse_a(2);
        pulse_a(3);
        check("glitch_ab_state", 64'(ab_state), 64'(0));

        for (int i = 0; i < 6; i++) apply((m_ab == 2'b00) ? 2'b11 : 2'b00, 10);
        check("err_saturate", 64'(err_count), 64'(EMAX));

        a_in = 1'b1;
        b_in = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_step", 64'(step), 64'(0));
        check("midrst_err_count", 64'(err_count), 64'(0));
        check("midrst_up_down", 64'(up_down), 64'(1));
        check("midrst_ab_state", 64'(ab_state), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("reinit_ab_state", 64'(ab_state), 64'(2'b10));
        check("reinit_up_down", 64'(up_down), 64'(1));
        m_ab   = 2'b10;
        m_dir  = 1'b1;
        m_errc = 0;

        for (int i = 0; i < 60; i++) begin
            nab = 2'($urandom_range(0, 3));
            apply(nab, $urandom_range(FL + 1, 12));
        end
        repeat (20) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        check("final_ab_state", 64'(ab_state), 64'(m_ab));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
